// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-RAM arbiter.
// Owner encoding tags which port the in-flight read belongs to.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_t;

    localparam int GNT_IM = 0;
    localparam int GNT_DR = 1;
    localparam int GNT_DW = 2;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/grant bundle for the arbiter.
// master = core (requester), slave = arbiter.
interface mem_arbiter_if;

    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_rresp;
    logic [31:0] imem_rdata;

    logic        dmem_wready;
    logic        dmem_wvalid;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;

    logic        dmem_rready;
    logic        dmem_rvalid;
    logic [31:0] dmem_raddr;
    logic        dmem_rresp;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_ready, imem_addr,
        output dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
        output dmem_rready, dmem_raddr,
        input  imem_valid, imem_rresp, imem_rdata,
        input  dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
    );

    modport slave (
        input  imem_ready, imem_addr,
        input  dmem_wready, dmem_waddr, dmem_wdata, dmem_wstrb,
        input  dmem_rready, dmem_raddr,
        output imem_valid, imem_rresp, imem_rdata,
        output dmem_wvalid, dmem_rvalid, dmem_rresp, dmem_rdata
    );

endinterface

// File: rtl/mem_arbiter_sel.sv
// Grant selection: store > load > fetch, with a fetch
// starvation counter that forces a fetch grant when saturated.
module mem_arb_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       i_im_req,
    input  logic       i_dw_req,
    input  logic       i_dr_req,
    output logic [2:0] o_gnt
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] r_starve;
    logic       w_force;

    assign w_force = i_im_req && (r_starve == SMAX);

    always_comb begin
        o_gnt = 3'b000;
        priority case (1'b1)
            w_force:  o_gnt[GNT_IM] = 1'b1;
            i_dw_req: o_gnt[GNT_DW] = 1'b1;
            i_dr_req: o_gnt[GNT_DR] = 1'b1;
            i_im_req: o_gnt[GNT_IM] = 1'b1;
            default:  o_gnt = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_starve <= 4'd0;
        end else if (!i_im_req || o_gnt[GNT_IM]) begin
            r_starve <= 4'd0;
        end else if (r_starve != SMAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch, load and store onto one single-port word RAM
// with 1-cycle read latency, range checking and read-data hold.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES  = 131072,
    parameter int STARVE_MAX = 4,
    localparam int AW = $clog2(MEM_BYTES) - 2
) (
    input  logic          clk,
    input  logic          resetb,
    mem_arbiter_if.slave  bus,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          bus_err
);

    logic [2:0]  w_gnt;
    logic        w_any;
    logic [31:0] w_addr;
    logic        w_inrange;
    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic        r_rng;
    logic        r_irresp;
    logic        r_drresp;
    logic [31:0] r_ihold;
    logic [31:0] r_dhold;
    logic [31:0] w_irdata;
    logic [31:0] w_drdata;
    logic        r_err;

    mem_arb_sel #(
        .STARVE_MAX(STARVE_MAX)
    ) u_sel (
        .clk      (clk),
        .resetb   (resetb),
        .i_im_req (bus.imem_ready),
        .i_dw_req (bus.dmem_wready),
        .i_dr_req (bus.dmem_rready),
        .o_gnt    (w_gnt)
    );

    assign w_any = |w_gnt;
    assign bus.imem_valid  = w_gnt[GNT_IM];
    assign bus.dmem_rvalid = w_gnt[GNT_DR];
    assign bus.dmem_wvalid = w_gnt[GNT_DW];

    always_comb begin
        w_addr = bus.imem_addr;
        unique case (1'b1)
            w_gnt[GNT_DW]: w_addr = bus.dmem_waddr;
            w_gnt[GNT_DR]: w_addr = bus.dmem_raddr;
            default:       w_addr = bus.imem_addr;
        endcase
    end

    assign w_inrange = w_addr < 32'(MEM_BYTES);

    // Out-of-range grants and zero-strobe stores never reach the RAM.
    always_comb begin
        mem_en = 1'b0;
        mem_we = 4'b0000;
        if (w_any && w_inrange) begin
            if (w_gnt[GNT_DW]) begin
                mem_en = |bus.dmem_wstrb;
                mem_we = bus.dmem_wstrb;
            end else begin
                mem_en = 1'b1;
            end
        end
    end

    assign mem_addr  = w_addr[AW+1:2];
    assign mem_wdata = bus.dmem_wdata;

    always_comb begin
        w_owner_nxt = OWN_NONE;
        unique case (1'b1)
            w_gnt[GNT_IM]: w_owner_nxt = OWN_IMEM;
            w_gnt[GNT_DR]: w_owner_nxt = OWN_DMEM;
            default:       w_owner_nxt = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_owner <= OWN_NONE;
            r_rng   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_rng   <= w_inrange;
            r_err   <= w_any && !w_inrange;
        end
    end

    always_comb begin
        w_irdata = r_ihold;
        w_drdata = r_dhold;
        if (r_owner == OWN_IMEM) begin
            w_irdata = r_rng ? mem_rdata : 32'h0;
        end
        if (r_owner == OWN_DMEM) begin
            w_drdata = r_rng ? mem_rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ihold  <= 32'h0;
            r_dhold  <= 32'h0;
            r_irresp <= 1'b0;
            r_drresp <= 1'b0;
        end else begin
            r_ihold <= w_irdata;
            r_dhold <= w_drdata;
            if (w_gnt[GNT_IM]) begin
                r_irresp <= w_inrange;
            end
            if (w_gnt[GNT_DR]) begin
                r_drresp <= w_inrange;
            end
        end
    end

    assign bus.imem_rdata = w_irdata;
    assign bus.dmem_rdata = w_drdata;
    assign bus.imem_rresp = r_irresp;
    assign bus.dmem_rresp = r_drresp;
    assign bus_err        = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// single-port RAM (1-cycle read latency) on the RAM side.
module tb_mem_arbiter;

    localparam int MEM_BYTES = 131072;
    localparam int AW = $clog2(MEM_BYTES) - 2;

    logic          clk;
    logic          resetb;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          bus_err;

    int checks;
    int errors;

    logic [31:0] ram [0:(MEM_BYTES/4)-1];

    mem_arbiter_if mif ();

    mem_arbiter #(
        .MEM_BYTES  (MEM_BYTES),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .bus       (mif),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic idle_inputs();
        mif.imem_ready  = 1'b0;
        mif.imem_addr   = 32'h0;
        mif.dmem_wready = 1'b0;
        mif.dmem_waddr  = 32'h0;
        mif.dmem_wdata  = 32'h0;
        mif.dmem_wstrb  = 4'h0;
        mif.dmem_rready = 1'b0;
        mif.dmem_raddr  = 32'h0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        #2;
        checks++; if (mif.imem_valid !== 1'b0) begin errors++; $display("FAIL rst_imem_valid got %b exp 0", mif.imem_valid); end
        checks++; if (mif.dmem_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dmem_rvalid got %b exp 0", mif.dmem_rvalid); end
        checks++; if (mif.dmem_wvalid !== 1'b0) begin errors++; $display("FAIL rst_dmem_wvalid got %b exp 0", mif.dmem_wvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", mem_en); end
        checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rst_mem_we got %h exp 0", mem_we); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %b exp 0", bus_err); end
        checks++; if (mif.imem_rdata !== 32'h0) begin errors++; $display("FAIL rst_imem_rdata got %h exp 0", mif.imem_rdata); end
        checks++; if (mif.dmem_rdata !== 32'h0) begin errors++; $display("FAIL rst_dmem_rdata got %h exp 0", mif.dmem_rdata); end
        checks++; if (mif.imem_rresp !== 1'b0 || mif.dmem_rresp !== 1'b0) begin errors++; $display("FAIL rst_rresp got %b%b exp 00", mif.imem_rresp, mif.dmem_rresp); end
    endtask

    task automatic test_imem_fetch();
        @(negedge clk);
        mif.imem_ready = 1'b1;
        mif.imem_addr  = 32'h0000_0010;
        #2;
        checks++; if (mif.imem_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b exp 1", mif.imem_valid); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 4'h0) begin errors++; $display("FAIL fetch_mem_en got en=%b we=%h exp en=1 we=0", mem_en, mem_we); end
        checks++; if (mem_addr !== 15'd4) begin errors++; $display("FAIL fetch_mem_addr got %0d exp 4", mem_addr); end
        @(negedge clk);
        mif.imem_ready = 1'b0;
        #2;
        checks++; if (mif.imem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata got %h exp deadbeef", mif.imem_rdata); end
        checks++; if (mif.imem_rresp !== 1'b1) begin errors++; $display("FAIL fetch_rresp got %b exp 1", mif.imem_rresp); end
        repeat (2) @(negedge clk);
        #2;
        checks++; if (mif.imem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_hold got %h exp deadbeef", mif.imem_rdata); end
        checks++; if (mif.imem_valid !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL fetch_idle got valid=%b en=%b exp 0 0", mif.imem_valid, mem_en); end
    endtask

    task automatic test_store_then_load();
        @(negedge clk);
        mif.dmem_wready = 1'b1;
        mif.dmem_waddr  = 32'h0000_0020;
        mif.dmem_wdata  = 32'h1234_5678;
        mif.dmem_wstrb  = 4'b0011;
        mif.dmem_rready = 1'b1;
        mif.dmem_raddr  = 32'h0000_0020;
        #2;
        checks++; if (mif.dmem_wvalid !== 1'b1 || mif.dmem_rvalid !== 1'b0) begin errors++; $display("FAIL st_first got w=%b r=%b exp w=1 r=0", mif.dmem_wvalid, mif.dmem_rvalid); end
        checks++; if (mem_we !== 4'b0011 || mem_addr !== 15'd8) begin errors++; $display("FAIL st_mem got we=%h addr=%0d exp we=3 addr=8", mem_we, mem_addr); end
        @(negedge clk);
        mif.dmem_wready = 1'b0;
        #2;
        checks++; if (mif.dmem_rvalid !== 1'b1 || mem_we !== 4'h0) begin errors++; $display("FAIL ld_second got r=%b we=%h exp r=1 we=0", mif.dmem_rvalid, mem_we); end
        @(negedge clk);
        mif.dmem_rready = 1'b0;
        #2;
        checks++; if (mif.dmem_rdata !== 32'hAABB_5678) begin errors++; $display("FAIL ld_merge got %h exp aabb5678", mif.dmem_rdata); end
        checks++; if (mif.dmem_rresp !== 1'b1) begin errors++; $display("FAIL ld_rresp got %b exp 1", mif.dmem_rresp); end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        mif.dmem_rready = 1'b1;
        mif.dmem_raddr  = 32'h0000_0010;
        mif.imem_ready  = 1'b1;
        mif.imem_addr   = 32'h0000_0020;
        for (int c = 1; c <= 4; c++) begin
            #2;
            checks++; if (mif.imem_valid !== 1'b0 || mif.dmem_rvalid !== 1'b1) begin errors++; $display("FAIL starve_c%0d got i=%b d=%b exp i=0 d=1", c, mif.imem_valid, mif.dmem_rvalid); end
            @(negedge clk);
        end
        #2;
        checks++; if (mif.imem_valid !== 1'b1 || mif.dmem_rvalid !== 1'b0) begin errors++; $display("FAIL starve_c5 got i=%b d=%b exp i=1 d=0", mif.imem_valid, mif.dmem_rvalid); end
        checks++; if (mem_addr !== 15'd8) begin errors++; $display("FAIL starve_addr got %0d exp 8", mem_addr); end
        @(negedge clk);
        #2;
        checks++; if (mif.imem_valid !== 1'b0 || mif.dmem_rvalid !== 1'b1) begin errors++; $display("FAIL starve_c6 got i=%b d=%b exp i=0 d=1", mif.imem_valid, mif.dmem_rvalid); end
        checks++; if (mif.imem_rdata !== 32'hAABB_5678) begin errors++; $display("FAIL starve_rdata got %h exp aabb5678", mif.imem_rdata); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        mif.dmem_rready = 1'b1;
        mif.dmem_raddr  = 32'(MEM_BYTES);
        #2;
        checks++; if (mif.dmem_rvalid !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL oor_grant got r=%b en=%b exp r=1 en=0", mif.dmem_rvalid, mem_en); end
        @(negedge clk);
        mif.dmem_rready = 1'b0;
        #2;
        checks++; if (mif.dmem_rresp !== 1'b0) begin errors++; $display("FAIL oor_rresp got %b exp 0", mif.dmem_rresp); end
        checks++; if (mif.dmem_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", mif.dmem_rdata); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", bus_err); end
        @(negedge clk);
        mif.dmem_wready = 1'b1;
        mif.dmem_waddr  = 32'h0000_0020;
        mif.dmem_wdata  = 32'hFFFF_FFFF;
        mif.dmem_wstrb  = 4'b0000;
        #2;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %b exp 0", bus_err); end
        checks++; if (mif.dmem_wvalid !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL nostrb got w=%b en=%b exp w=1 en=0", mif.dmem_wvalid, mem_en); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        mif.imem_ready = 1'b1;
        mif.imem_addr  = 32'h0000_0010;
        @(posedge clk);
        #1;
        resetb = 1'b0;
        mif.imem_ready = 1'b0;
        #2;
        checks++; if (mif.imem_rdata !== 32'h0 || mif.imem_rresp !== 1'b0) begin errors++; $display("FAIL rmid_rdata got %h/%b exp 0/0", mif.imem_rdata, mif.imem_rresp); end
        checks++; if (mem_en !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rmid_en got en=%b err=%b exp 0 0", mem_en, bus_err); end
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        #2;
        checks++; if (mif.imem_rdata !== 32'h0) begin errors++; $display("FAIL rmid_after got %h exp 0", mif.imem_rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_rdata = 32'h0;
        for (int i = 0; i < MEM_BYTES / 4; i++) ram[i] = 32'h0;
        ram[4] = 32'hDEAD_BEEF;
        ram[8] = 32'hAABB_CCDD;
        test_reset();
        test_imem_fetch();
        test_store_then_load();
        test_starvation();
        test_out_of_range();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
